// File: rtl/serial_fsm.sv
// Serial-to-parallel capture FSM: on a start strobe, shifts in WIDTH bits and presents them on out.
// Define SERIAL_FSM_LSB_FIRST_EN to shift LSB first; the default build shifts MSB first.
module serial_fsm #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             reset,
    input  logic             start,
    input  logic             clk,
    input  logic             in,
    output logic [WIDTH-1:0] out
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] shift_nxt;

    // Shift register contents after absorbing the current serial bit.
    always_comb begin
`ifdef SERIAL_FSM_LSB_FIRST_EN
        shift_nxt = {in, shift_q[WIDTH-1:1]};
`else
        shift_nxt = {shift_q[WIDTH-2:0], in};
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        out_d   = out_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StShift;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                shift_d = shift_nxt;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LastBit) begin
                    out_d   = shift_nxt;
                    state_d = StDone;
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_serial_fsm.sv
// Directed self-checking bench for serial_fsm; expected words are hand-computed per bit order.
module tb_serial_fsm;

    logic       reset;
    logic       start;
    logic       clk;
    logic       in;
    logic [7:0] out;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef SERIAL_FSM_LSB_FIRST_EN
    localparam logic [7:0] ExpBasic = 8'h35;
    localparam logic [7:0] ExpF0    = 8'h0F;
    localparam logic [7:0] Exp5A    = 8'h5A;
    localparam logic [7:0] ExpFF    = 8'hFF;
    localparam logic [7:0] Exp01    = 8'h80;
`else
    localparam logic [7:0] ExpBasic = 8'hAC;
    localparam logic [7:0] ExpF0    = 8'hF0;
    localparam logic [7:0] Exp5A    = 8'h5A;
    localparam logic [7:0] ExpFF    = 8'hFF;
    localparam logic [7:0] Exp01    = 8'h01;
`endif

    serial_fsm #(.WIDTH(8)) dut (
        .reset(reset),
        .start(start),
        .clk  (clk),
        .in   (in),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, take one rising edge, then settle 1 ns before any check.
    task automatic step(input logic s, input logic d);
        start = s;
        in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        n_cmp++;
        assert (out === exp)
        else begin
            n_bad++;
            $error("FAIL %s: out=%h expected %h", tag, out, exp);
        end
    endtask

    // Start edge plus 8 data edges sent bit 7 first; optional extra start pulse at data edge restart_at.
    task automatic run_frame(input string tag, input logic [7:0] w, input logic [7:0] prev,
                             input logic [7:0] exp, input int restart_at);
        step(1'b1, 1'b0);
        chk({tag, "_startedge"}, prev);
        for (int i = 0; i < 8; i++) begin
            step(i == restart_at, w[7-i]);
            if (i < 7) chk({tag, "_hold"}, prev);
            else       chk({tag, "_done"}, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        in    = 1'b1;

        // Reset with start/in active
        step(1'b1, 1'b1);
        chk("reset_edge1", 8'h00);
        step(1'b1, 1'b1);
        chk("reset_edge2", 8'h00);
        reset = 1'b0;

        // Idle with unknown serial input
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'bx);
            chk("idle_x", 8'h00);
        end

        // Basic frame 1,0,1,0,1,1,0,0
        run_frame("basic", 8'b1010_1100, 8'h00, ExpBasic, -1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, i[0]);
            chk("basic_hold200ns", ExpBasic);
        end

        // Start re-pulsed at data edge 4 must not restart the frame
        run_frame("restart", 8'b1111_0000, ExpBasic, ExpF0, 3);
        step(1'b0, 1'b0);
        chk("restart_done_state", ExpF0);
        step(1'b0, 1'b0);
        chk("restart_idle", ExpF0);

        // Mid-frame reset after 5 data bits
        step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            chk("midreset_partial", ExpF0);
        end
        reset = 1'b1;
        step(1'b0, 1'b1);
        chk("midreset_clear", 8'h00);
        reset = 1'b0;
        step(1'b0, 1'b0);
        chk("midreset_idle", 8'h00);
        run_frame("after_reset", 8'h5A, 8'h00, Exp5A, -1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Continuous start: FF then 01, second completion 10 edges after the first
        step(1'b1, 1'b0);
        chk("cont_startedge", Exp5A);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1);
            if (i < 7) chk("cont_ff_hold", Exp5A);
            else       chk("cont_ff_done", ExpFF);
        end
        step(1'b1, 1'b0);
        chk("cont_done_cycle", ExpFF);
        step(1'b1, 1'b0);
        chk("cont_idle_cycle", ExpFF);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 7) ? 1'b1 : 1'b0);
            if (i < 7) chk("cont_01_hold", ExpFF);
            else       chk("cont_01_done", Exp01);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
